// File: rtl/pbkdf2_f_block.sv
// PBKDF2-HMAC-SHA256 F-function controller: drives an external HMAC engine
// through c chained iterations and returns T_i = U_1 ^ ... ^ U_c.
module pbkdf2_f_block #(
  parameter int ITER_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [511:0]      key_i,
  input  logic [511:0]      salt_i,
  input  logic [5:0]        salt_len_i,
  input  logic [ITER_W-1:0] iter_i,
  input  logic [31:0]       blk_idx_i,
  input  logic              v_i,
  output logic              r_o,
  output logic [255:0]      t_o,
  output logic              err_o,
  output logic              v_o,
  input  logic              r_i,
  output logic [511:0]      hmac_key_o,
  output logic [511:0]      hmac_msg_o,
  output logic [5:0]        hmac_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  input  logic [255:0]      hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o
);

  localparam logic [5:0] MAX_SALT = 6'd51;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  state_e            r_state, w_next;
  logic              r_primed;
  logic [511:0]      r_key, r_salt;
  logic [5:0]        r_len;
  logic [ITER_W-1:0] r_iter, r_cnt;
  logic [31:0]       r_idx;
  logic [255:0]      r_u, r_acc, r_t;
  logic              r_err;

  logic              w_accept, w_bad_len, w_last, w_prf;
  logic [ITER_W-1:0] w_iter_eff;
  logic [511:0]      w_salt_mask, w_msg1;

  assign w_accept    = (r_state == IDLE) && r_primed && v_i;
  assign w_bad_len   = salt_len_i > MAX_SALT;
  assign w_iter_eff  = (r_iter == '0) ? ITER_W'(1) : r_iter;
  assign w_last      = (r_cnt == w_iter_eff);
  assign w_prf       = (r_state == WAIT) && hmac_v_i;
  // keep only the first salt_len_i bytes; the block index lands right after them
  assign w_salt_mask = ~({512{1'b1}} >> {salt_len_i, 3'b000});
  assign w_msg1      = r_salt | ({r_idx, 480'b0} >> {r_len, 3'b000});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_bad_len ? DONE : SEND;
      SEND: if (hmac_r_i) w_next = WAIT;
      WAIT: if (hmac_v_i) w_next = w_last ? DONE : SEND;
      DONE: if (r_i)      w_next = IDLE;
      default:            w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_primed <= 1'b0;
      r_key    <= '0;
      r_salt   <= '0;
      r_len    <= '0;
      r_iter   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_u      <= '0;
      r_acc    <= '0;
      r_t      <= '0;
      r_err    <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      if (w_accept) begin
        r_key  <= key_i;
        r_salt <= salt_i & w_salt_mask;
        r_len  <= salt_len_i;
        r_iter <= iter_i;
        r_idx  <= blk_idx_i;
        r_cnt  <= ITER_W'(1);
        r_acc  <= '0;
        r_err  <= w_bad_len;
        if (w_bad_len) r_t <= '0;
      end
      // cnt stops at the terminal count, so it never wraps even at the max iteration
      if (w_prf) begin
        r_u   <= hmac_prf_i;
        r_acc <= r_acc ^ hmac_prf_i;
        if (w_last) r_t   <= r_acc ^ hmac_prf_i;
        else        r_cnt <= r_cnt + ITER_W'(1);
      end
    end
  end

  always_comb begin
    r_o        = r_primed && (r_state == IDLE);
    v_o        = (r_state == DONE);
    t_o        = r_t;
    err_o      = r_err && (r_state == DONE);
    hmac_key_o = r_key;
    hmac_v_o   = (r_state == SEND);
    hmac_r_o   = (r_state == WAIT);
    hmac_msg_o = '0;
    hmac_len_o = '0;
    if (r_state == SEND) begin
      if (r_cnt == ITER_W'(1)) begin
        hmac_msg_o = w_msg1;
        hmac_len_o = r_len + 6'd4;
      end else begin
        hmac_msg_o = {r_u, 256'b0};
        hmac_len_o = 6'd32;
      end
    end
  end

endmodule

// File: tb/tb_pbkdf2_f_block.sv
// Bench for pbkdf2_f_block: behavioural HMAC-SHA256 engine stub, PBKDF2 F model,
// scoreboard compare on the result port, directed RFC-style vectors.
module tb_pbkdf2_f_block;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic [511:0] key_i, salt_i;
  logic [5:0]   salt_len_i;
  logic [31:0]  iter_i, blk_idx_i;
  logic         v_i, r_o, err_o, v_o, r_i;
  logic [255:0] t_o, hmac_prf_i;
  logic [511:0] hmac_key_o, hmac_msg_o;
  logic [5:0]   hmac_len_o;
  logic         hmac_v_o, hmac_r_i, hmac_v_i, hmac_r_o;

  pbkdf2_f_block #(.ITER_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .key_i(key_i), .salt_i(salt_i),
    .salt_len_i(salt_len_i), .iter_i(iter_i), .blk_idx_i(blk_idx_i),
    .v_i(v_i), .r_o(r_o), .t_o(t_o), .err_o(err_o), .v_o(v_o), .r_i(r_i),
    .hmac_key_o(hmac_key_o), .hmac_msg_o(hmac_msg_o), .hmac_len_o(hmac_len_o),
    .hmac_v_o(hmac_v_o), .hmac_r_i(hmac_r_i), .hmac_prf_i(hmac_prf_i),
    .hmac_v_i(hmac_v_i), .hmac_r_o(hmac_r_o)
  );

  initial forever #5 clk_i = ~clk_i;

  localparam logic [511:0] PW   = {64'h70617373776f7264, 448'b0};
  localparam logic [511:0] SALT = {32'h73616c74, {15{32'hdeadbeef}}};
  localparam logic [511:0] MSG1 = {32'h73616c74, 32'h00000001, 448'b0};
  localparam logic [255:0] C1 = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] C2 = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
  localparam logic [255:0] C4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

  localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [0:63][31:0] SHA_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct packed {logic [255:0] t; logic err;} res_t;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[511-32*t -: 32];
      else begin
        s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  // HMAC-SHA256 with a 64-byte key block and a message of at most 55 bytes
  function automatic logic [255:0] hmac(input logic [511:0] k, input logic [511:0] m, input int len);
    logic [511:0] blk;
    logic [255:0] inner;
    blk = m & ~({512{1'b1}} >> (8 * len));
    blk[511-8*len -: 8] = 8'h80;
    blk[63:0] = 64'((64 + len) * 8);
    inner = sha_blk(sha_blk(H0, k ^ {64{8'h36}}), blk);
    return sha_blk(sha_blk(H0, k ^ {64{8'h5c}}), {inner, 8'h80, 184'b0, 64'd768});
  endfunction

  function automatic res_t pbkdf2_f(input logic [511:0] k, input logic [511:0] s, input int sl,
                                    input logic [31:0] it, input logic [31:0] ix);
    res_t r;
    logic [511:0] m;
    logic [255:0] u;
    int c;
    if (sl > 51) begin
      r.t = '0; r.err = 1'b1;
      return r;
    end
    m = '0;
    for (int b = 0; b < sl; b++) m[511-8*b -: 8] = s[511-8*b -: 8];
    for (int b = 0; b < 4; b++) m[511-8*(sl+b) -: 8] = ix[31-8*b -: 8];
    c = (it == 0) ? 1 : int'(it);
    u = hmac(k, m, sl + 4);
    r.t = u;
    for (int j = 2; j <= c; j++) begin
      u = hmac(k, {u, 256'b0}, 32);
      r.t ^= u;
    end
    r.err = 1'b0;
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- HMAC engine stub ----------------
  int           st = 0, sd = 0, maxd = 0, hv_seen = 0;
  logic [511:0] s_msg, s_key;
  logic [5:0]   s_len;
  logic [255:0] s_prf;
  logic [511:0] cap_msg [$];
  logic [5:0]   cap_len [$];

  initial begin
    hmac_r_i = 1'b0; hmac_v_i = 1'b0; hmac_prf_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        st = 0; hmac_r_i = 1'b0; hmac_v_i = 1'b0;
      end else begin
        if (hmac_v_o) hv_seen++;
        if (st == 4) begin
          hmac_v_i = 1'b0; hmac_prf_i = rnd512()[255:0]; st = 0;
        end
        if (st == 2) begin
          hmac_r_i = 1'b0;
          chk("hmac_v_low_in_wait", hmac_v_o, 1'b0);
          s_prf = hmac(s_key, s_msg, int'(s_len));
          sd = $urandom_range(0, maxd); st = 3;
        end
        if (st == 3) begin
          if (sd == 0) begin hmac_v_i = 1'b1; hmac_prf_i = s_prf; st = 4; end
          else sd--;
        end
        if (st == 0 && hmac_v_o) begin
          s_msg = hmac_msg_o; s_len = hmac_len_o; s_key = hmac_key_o;
          sd = $urandom_range(0, maxd); st = 1;
        end
        if (st == 1) begin
          chk("send_hold_v", hmac_v_o, 1'b1);
          chk("send_hold_msg", hmac_msg_o, s_msg);
          chk("send_hold_len", hmac_len_o, s_len);
          chk("send_hold_key", hmac_key_o, s_key);
          if (sd == 0) begin
            hmac_r_i = 1'b1; cap_msg.push_back(s_msg); cap_len.push_back(s_len); st = 2;
          end else sd--;
        end
      end
    end
  end

  // ---------------- result compare ----------------
  res_t         exp_q [$];
  res_t         e_cur;
  int           done_cnt = 0, issued = 0;
  bit           in_res = 1'b0, bp = 1'b0;
  logic [255:0] held_t, last_t;
  logic         last_err;

  initial begin
    r_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_q.delete(); in_res = 1'b0; r_i = 1'b0;
      end else if (v_o) begin
        if (!in_res) begin
          if (exp_q.size() == 0) chk("unexpected_result", v_o, 1'b0);
          else begin
            e_cur = exp_q.pop_front();
            chk("t_o", t_o, e_cur.t);
            chk("err_o", err_o, e_cur.err);
          end
          held_t = t_o; in_res = 1'b1;
        end else chk("t_o_stable", t_o, held_t);
        r_i = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (r_i) begin
          in_res = 1'b0; done_cnt++; last_t = t_o; last_err = err_o;
        end
      end else r_i = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [511:0] k, input logic [511:0] s, input logic [5:0] sl,
                       input logic [31:0] it, input logic [31:0] ix);
    int n = 0;
    key_i = k; salt_i = s; salt_len_i = sl; iter_i = it; blk_idx_i = ix; v_i = 1'b1;
    while (!r_o && n < 5000) begin @(negedge clk_i); n++; end
    if (!r_o) begin
      chk("accept_timeout", r_o, 1'b1);
      v_i = 1'b0;
      return;
    end
    chk("accept_after_done", done_cnt, issued);
    exp_q.push_back(pbkdf2_f(k, s, int'(sl), it, ix));
    issued++;
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt != issued && n < budget) begin @(negedge clk_i); n++; end
    if (done_cnt != issued) chk("done_timeout", done_cnt, issued);
  endtask

  task automatic chk_reset_outs();
    chk("rst_r_o", r_o, 1'b0);
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_err_o", err_o, 1'b0);
    chk("rst_t_o", t_o, '0);
    chk("rst_hmac_v_o", hmac_v_o, 1'b0);
    chk("rst_hmac_r_o", hmac_r_o, 1'b0);
    chk("rst_hmac_key", hmac_key_o, '0);
    chk("rst_hmac_msg", hmac_msg_o, '0);
    chk("rst_hmac_len", hmac_len_o, '0);
  endtask

  initial begin
    int base, hv0, n;
    res_t m;
    logic [511:0] s51, cm;
    v_i = 1'b0; key_i = '0; salt_i = '0; salt_len_i = '0; iter_i = '0; blk_idx_i = '0;

    #3 rst_ni = 1'b0;
    #1 chk_reset_outs();
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    #1 chk("r_o_after_release", r_o, 1'b0);
    @(negedge clk_i);
    chk("r_o_rise", r_o, 1'b1);

    // model pinned against known vectors
    m = pbkdf2_f(PW, SALT, 4, 1, 1);
    chk("model_c1", m.t, C1);
    m = pbkdf2_f(PW, SALT, 4, 2, 1);
    chk("model_c2", m.t, C2);

    // c=1
    maxd = 0; bp = 1'b0; base = cap_msg.size();
    issue(PW, SALT, 6'd4, 32'd1, 32'd1);
    wait_done(300);
    chk("c1_t", last_t, C1);
    chk("c1_err", last_err, 1'b0);
    chk("c1_handshakes", cap_msg.size() - base, 1);
    if (cap_msg.size() > base) begin
      chk("c1_msg0", cap_msg[base], MSG1);
      chk("c1_len0", cap_len[base], 6'd8);
    end

    // c=2: second message is U_1 (== C1) with len 32
    base = cap_msg.size();
    issue(PW, SALT, 6'd4, 32'd2, 32'd1);
    wait_done(300);
    chk("c2_t", last_t, C2);
    chk("c2_handshakes", cap_msg.size() - base, 2);
    if (cap_msg.size() > base + 1) begin
      chk("c2_msg1", cap_msg[base+1], {C1, 256'b0});
      chk("c2_len1", cap_len[base+1], 6'd32);
    end

    // c=4096
    base = cap_msg.size();
    issue(PW, SALT, 6'd4, 32'd4096, 32'd1);
    wait_done(30000);
    chk("c4096_t", last_t, C4096);
    chk("c4096_handshakes", cap_msg.size() - base, 4096);

    // iter 0 behaves as 1
    issue(PW, SALT, 6'd4, 32'd0, 32'd1);
    wait_done(300);
    chk("iter0_t", last_t, C1);

    // salt_len 52 rejected without touching the engine
    hv0 = hv_seen;
    issue(PW, SALT, 6'd52, 32'd5, 32'd1);
    chk("err_fast_v", v_o, 1'b1);
    chk("err_fast_e", err_o, 1'b1);
    wait_done(300);
    chk("err_t", last_t, '0);
    chk("err_flag", last_err, 1'b1);
    chk("err_no_hmac_v", hv_seen - hv0, 0);

    // salt_len 51: INT(i) occupies bytes 51..54
    maxd = 7; bp = 1'b1; s51 = rnd512(); base = cap_msg.size();
    issue(rnd512(), s51, 6'd51, 32'd3, 32'ha5c30102);
    wait_done(3000);
    if (cap_msg.size() > base) begin
      cm = cap_msg[base];
      chk("s51_len", cap_len[base], 6'd55);
      chk("s51_idx", cm[511-8*51 -: 32], 32'ha5c30102);
      chk("s51_tail", cm[511-8*55:0], '0);
    end else chk("s51_handshakes", cap_msg.size() - base, 3);

    // handshake stress with a queued second request each round
    for (int k = 0; k < 3; k++) begin
      issue(rnd512(), rnd512(), (k == 0) ? 6'd0 : 6'($urandom_range(0, 51)),
            $urandom_range(1, 5), $urandom());
      issue(rnd512(), rnd512(), 6'($urandom_range(0, 51)), $urandom_range(1, 5), $urandom());
      wait_done(4000);
    end

    // reset during WAIT of iteration 3 of 10
    maxd = 2; bp = 1'b0; base = cap_msg.size(); n = 0;
    issue(PW, SALT, 6'd4, 32'd10, 32'd1);
    while (cap_msg.size() - base < 3 && n < 500) begin @(negedge clk_i); n++; end
    chk("rst_reach_iter3", cap_msg.size() - base, 3);
    @(negedge clk_i);
    chk("rst_in_wait", hmac_r_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1 chk_reset_outs();
    repeat (2) @(negedge clk_i);
    issued = done_cnt;
    #2 rst_ni = 1'b1;
    #1 chk("r_o_after_release2", r_o, 1'b0);
    @(negedge clk_i);
    chk("r_o_rise2", r_o, 1'b1);

    maxd = 0;
    issue(PW, SALT, 6'd4, 32'd1, 32'd1);
    wait_done(300);
    chk("post_rst_c1_t", last_t, C1);

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
